// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard unit.
// Entry fields are sized to the largest supported register and latency widths.
package fwd_pkg;

    localparam int RBITS_MAX = 8;
    localparam int LBITS_MAX = 8;

    function automatic int fwd_selw(input int nfwd);
        return $clog2(nfwd + 1);
    endfunction

    localparam int SELW   = fwd_selw(2);
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                 vld;
        logic [RBITS_MAX-1:0] rd;
        logic [LBITS_MAX-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/fwd_sb_entry.sv
// One scoreboard entry: loads rd/latency, counts down, retires at cnt==1.
// Reports whether its rd matches any used ID-stage operand.
module fwd_sb_entry
    import fwd_pkg::*;
#(
    parameter int NSRC  = 2,
    parameter int RBITS = 5,
    parameter int LBITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [RBITS-1:0]      i_rd,
    input  logic [LBITS-1:0]      i_lat,
    input  logic [NSRC*RBITS-1:0] i_src,
    input  logic [NSRC-1:0]       i_src_vld,
    output logic                  o_vld,
    output logic                  o_match
);

    sb_entry_t r_ent;
    logic      w_match;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ent <= '0;
        end else if (i_load) begin
            r_ent.vld <= 1'b1;
            r_ent.rd  <= RBITS_MAX'(i_rd);
            r_ent.cnt <= (i_lat == '0) ? LBITS_MAX'(1) : LBITS_MAX'(i_lat);
        end else if (r_ent.vld) begin
            // The final busy cycle is the one where cnt reads 1.
            if (r_ent.cnt <= LBITS_MAX'(1)) begin
                r_ent.vld <= 1'b0;
                r_ent.cnt <= '0;
            end else begin
                r_ent.cnt <= r_ent.cnt - LBITS_MAX'(1);
            end
        end
    end

    always_comb begin
        w_match = 1'b0;
        for (int j = 0; j < NSRC; j++) begin
            if (r_ent.vld && i_src_vld[j] && (r_ent.rd != '0) &&
                (r_ent.rd == RBITS_MAX'(i_src[j*RBITS +: RBITS]))) begin
                w_match = 1'b1;
            end
        end
    end

    assign o_vld   = r_ent.vld;
    assign o_match = w_match;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, load-use detection and a multi-cycle-op scoreboard.
// Forwarding and stall are combinational; iss_rdy depends only on registered entries.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter  int NFWD  = 2,
    parameter  int NSRC  = 2,
    parameter  int RBITS = 5,
    parameter  int NPEND = 4,
    parameter  int LBITS = 4,
    localparam int SEL_W = fwd_selw(NFWD)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NFWD-1:0]       i_fwd_wr_en,
    input  logic [NFWD*RBITS-1:0] i_fwd_rd,
    input  logic [NSRC*RBITS-1:0] i_ex_src,
    output logic [NSRC*SEL_W-1:0] o_fwd_sel,
    input  logic [NSRC*RBITS-1:0] i_id_src,
    input  logic [NSRC-1:0]       i_id_src_vld,
    input  logic                  i_ex_is_load,
    input  logic [RBITS-1:0]      i_ex_rd,
    input  logic                  i_iss_vld,
    input  logic [RBITS-1:0]      i_iss_rd,
    input  logic [LBITS-1:0]      i_iss_lat,
    output logic                  o_iss_rdy,
    output logic                  o_stall,
    output logic [15:0]           o_stall_cnt
);

    logic [NPEND-1:0] w_ent_vld;
    logic [NPEND-1:0] w_ent_match;
    logic [NPEND-1:0] w_alloc;
    logic             w_found;
    logic             w_iss_acc;
    logic             w_load_use;
    logic             w_sb_haz;
    logic             w_stall;
    logic [15:0]      r_stall_cnt;

    always_comb begin
        o_fwd_sel = '0;
        for (int j = 0; j < NSRC; j++) begin
            o_fwd_sel[j*SEL_W +: SEL_W] = SEL_W'(FWD_RF);
            // Walk from the farthest stage so the nearest match overwrites.
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (i_fwd_wr_en[k] && (i_fwd_rd[k*RBITS +: RBITS] != '0) &&
                    (i_fwd_rd[k*RBITS +: RBITS] == i_ex_src[j*RBITS +: RBITS])) begin
                    o_fwd_sel[j*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
        end
        if (!i_rst_n) begin
            o_fwd_sel = '0;
        end
    end

    always_comb begin
        w_load_use = 1'b0;
        for (int j = 0; j < NSRC; j++) begin
            if (i_ex_is_load && (i_ex_rd != '0) && i_id_src_vld[j] &&
                (i_id_src[j*RBITS +: RBITS] == i_ex_rd)) begin
                w_load_use = 1'b1;
            end
        end
    end

    always_comb begin
        w_alloc = '0;
        w_found = 1'b0;
        for (int e = 0; e < NPEND; e++) begin
            if (!w_ent_vld[e] && !w_found) begin
                w_alloc[e] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    assign o_iss_rdy = i_rst_n & w_found;
    // r0 is never a real dependency, so such an issue is acked without taking an entry.
    assign w_iss_acc = i_iss_vld & o_iss_rdy & (i_iss_rd != '0);
    assign w_sb_haz  = |w_ent_match;
    assign w_stall   = i_rst_n & (w_load_use | w_sb_haz);
    assign o_stall   = w_stall;

    for (genvar e = 0; e < NPEND; e++) begin : g_ent
        fwd_sb_entry #(
            .NSRC  (NSRC),
            .RBITS (RBITS),
            .LBITS (LBITS)
        ) u_ent (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_load    (w_iss_acc & w_alloc[e]),
            .i_rd      (i_iss_rd),
            .i_lat     (i_iss_lat),
            .i_src     (i_id_src),
            .i_src_vld (i_id_src_vld),
            .o_vld     (w_ent_vld[e]),
            .o_match   (w_ent_match[e])
        );
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with hand-computed expectations.
module tb_fwd_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  fwd_wr_en;
    logic [9:0]  fwd_rd;
    logic [9:0]  ex_src;
    logic [3:0]  fwd_sel;
    logic [9:0]  id_src;
    logic [1:0]  id_src_vld;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        iss_vld;
    logic [4:0]  iss_rd;
    logic [3:0]  iss_lat;
    logic        iss_rdy;
    logic        stall;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    fwd_hazard_unit dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_fwd_wr_en  (fwd_wr_en),
        .i_fwd_rd     (fwd_rd),
        .i_ex_src     (ex_src),
        .o_fwd_sel    (fwd_sel),
        .i_id_src     (id_src),
        .i_id_src_vld (id_src_vld),
        .i_ex_is_load (ex_is_load),
        .i_ex_rd      (ex_rd),
        .i_iss_vld    (iss_vld),
        .i_iss_rd     (iss_rd),
        .i_iss_lat    (iss_lat),
        .o_iss_rdy    (iss_rdy),
        .o_stall      (stall),
        .o_stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        fwd_wr_en  = '0;
        fwd_rd     = '0;
        ex_src     = '0;
        id_src     = '0;
        id_src_vld = '0;
        ex_is_load = 1'b0;
        ex_rd      = '0;
        iss_vld    = 1'b0;
        iss_rd     = '0;
        iss_lat    = '0;

        step();
        step();
        // Outputs forced idle in reset even with matching inputs
        fwd_wr_en  = 2'b11;
        fwd_rd     = {5'd16, 5'd16};
        ex_src     = {5'd0, 5'd16};
        ex_is_load = 1'b1;
        ex_rd      = 5'd8;
        id_src     = {5'd8, 5'd0};
        id_src_vld = 2'b10;
        #1;
        chk("rst_fwd_sel", fwd_sel, 4'h0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_iss_rdy", iss_rdy, 1'b0);
        chk("rst_stall_cnt", stall_cnt, 16'd0);

        ex_is_load = 1'b0;
        id_src_vld = 2'b00;
        rst_n      = 1'b1;
        step();
        chk("post_rst_iss_rdy", iss_rdy, 1'b1);
        chk("post_rst_stall", stall, 1'b0);

        // Forwarding priority
        #1;
        chk("fwd_prio_near", fwd_sel, 4'b0001);
        fwd_wr_en = 2'b10;
        #1;
        chk("fwd_prio_far", fwd_sel, 4'b0010);
        fwd_wr_en = 2'b11;
        fwd_rd    = {5'd3, 5'd5};
        ex_src    = {5'd3, 5'd5};
        #1;
        chk("fwd_two_ports", fwd_sel, 4'b1001);
        fwd_wr_en = 2'b00;
        #1;
        chk("fwd_no_wr", fwd_sel, 4'b0000);

        // Register zero never forwards or stalls
        fwd_wr_en  = 2'b11;
        fwd_rd     = '0;
        ex_src     = '0;
        #1;
        chk("r0_fwd_sel", fwd_sel, 4'b0000);
        ex_is_load = 1'b1;
        ex_rd      = 5'd0;
        id_src     = '0;
        id_src_vld = 2'b11;
        #1;
        chk("r0_load_stall", stall, 1'b0);

        // Load-use
        fwd_wr_en  = 2'b00;
        ex_rd      = 5'd8;
        id_src     = {5'd8, 5'd1};
        id_src_vld = 2'b10;
        #1;
        chk("lu_stall", stall, 1'b1);
        step();
        ex_is_load = 1'b1;
        id_src_vld = 2'b00;
        #1;
        chk("lu_stall_cnt", stall_cnt, 16'd1);
        chk("lu_unused_port", stall, 1'b0);
        ex_is_load = 1'b0;

        // Latency 3
        id_src     = {5'd0, 5'd9};
        id_src_vld = 2'b01;
        iss_vld    = 1'b1;
        iss_rd     = 5'd9;
        iss_lat    = 4'd3;
        #1;
        chk("lat3_pre", stall, 1'b0);
        step();
        iss_vld = 1'b0;
        #1;
        chk("lat3_c1", stall, 1'b1);
        step();
        chk("lat3_c2", stall, 1'b1);
        step();
        chk("lat3_c3", stall, 1'b1);
        step();
        chk("lat3_done", stall, 1'b0);
        chk("lat3_stall_cnt", stall_cnt, 16'd4);

        // Latency 0 behaves as 1
        iss_vld = 1'b1;
        iss_lat = 4'd0;
        step();
        iss_vld = 1'b0;
        #1;
        chk("lat0_c1", stall, 1'b1);
        step();
        chk("lat0_done", stall, 1'b0);
        chk("lat0_stall_cnt", stall_cnt, 16'd5);

        // Fill the table with lat=5
        id_src_vld = 2'b00;
        iss_vld    = 1'b1;
        iss_lat    = 4'd5;
        iss_rd     = 5'd10;
        step();
        iss_rd = 5'd11;
        step();
        iss_rd = 5'd12;
        step();
        iss_rd = 5'd13;
        step();
        chk("full_rdy0", iss_rdy, 1'b0);
        iss_rd  = 5'd14;
        iss_lat = 4'd1;
        step();
        chk("full_rdy0_retiring", iss_rdy, 1'b0);
        iss_vld = 1'b0;
        step();
        chk("full_rdy1_after_retire", iss_rdy, 1'b1);
        id_src     = {5'd0, 5'd14};
        id_src_vld = 2'b01;
        #1;
        chk("full_fifth_ignored", stall, 1'b0);
        id_src = {5'd0, 5'd11};
        #1;
        chk("full_rd11_busy", stall, 1'b1);
        id_src_vld = 2'b00;
        #1;
        chk("full_stall_cnt", stall_cnt, 16'd5);

        // Retire rd 11, leaving two pending, then reset mid-op
        step();
        rst_n      = 1'b0;
        id_src     = {5'd12, 5'd13};
        id_src_vld = 2'b11;
        #1;
        chk("midrst_stall", stall, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        chk("midrst_iss_rdy", iss_rdy, 1'b1);
        chk("midrst_stall_after", stall, 1'b0);
        chk("midrst_stall_cnt", stall_cnt, 16'd0);
        step();
        chk("midrst_stall_next", stall, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter NFWD, default 2: number of forwarding source stages; stage 0 is nearest (EX/MEM), stage 1 is next (MEM/WB).
REQ-003 Parameter NSRC, default 2: number of operand read ports (rs, rt).
REQ-004 Parameter RBITS, default 5: register-index width.
REQ-005 Parameter NPEND, default 4: scoreboard entries for multi-cycle ops.
REQ-006 Parameter LBITS, default 4: latency field width.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 fwd_wr_en  in  NFWD  per-stage RegWrite.
REQ-010 fwd_rd  in  NFWD*RBITS  per-stage destination register.
REQ-011 ex_src  in  NSRC*RBITS  EX-stage operand registers.
REQ-012 fwd_sel  out  NSRC*SELW  per-port mux select; SELW=clog2(NFWD+1); 0 = register file, k+1 = stage k.
REQ-013 id_src, id_src_vld  in  NSRC*RBITS, NSRC  ID-stage operands and their use flags.
REQ-014 ex_is_load, ex_rd  in  1, RBITS  load in EX and its destination.
REQ-015 iss_vld, iss_rd, iss_lat  in  1, RBITS, LBITS  multi-cycle op issue request.
REQ-016 iss_rdy  out  1  scoreboard has a free entry.
REQ-017 stall  out  1  freeze PC and IF/ID, bubble ID/EX.
REQ-018 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-019 fwd_sel for each port SHALL be combinational: the lowest k with fwd_wr_en[k]=1, fwd_rd[k]==ex_src[j], and fwd_rd[k]!=0 selects k+1; otherwise 0.
REQ-020 Load-use hazard SHALL be asserted when ex_is_load=1, ex_rd!=0, and any port j has id_src_vld[j]=1 with id_src[j]==ex_rd.
REQ-021 Scoreboard hazard SHALL be asserted when any valid entry's rd equals any id_src[j] with id_src_vld[j]=1 and id_src[j]!=0.
REQ-022 stall SHALL be the combinational OR of the load-use and scoreboard hazards.
REQ-023 Each entry SHALL hold valid, rd, and a down-counter cnt.
REQ-024 Issue accepted (iss_vld & iss_rdy) SHALL load the lowest-index free entry on the next edge with cnt=max(iss_lat,1); iss_rd=0 SHALL be accepted but never marked busy.
REQ-025 Every valid entry SHALL decrement each cycle; an entry with cnt==1 SHALL clear valid on that edge, so its rd is busy for exactly iss_lat cycles after issue.
REQ-026 iss_rdy SHALL depend only on registered state: 1 iff at least one entry is invalid at cycle start; an entry retiring this cycle is not reusable until the next cycle.
REQ-027 iss_vld while iss_rdy=0 SHALL be ignored, with no state change.
REQ-028 Duplicate rd in two entries SHALL be allowed; rd stays busy until both retire.
REQ-029 stall_cnt SHALL increment on each edge where stall=1 and saturate at 16'hFFFF.

Reset
REQ-030 While rst_n=0 at an edge, all entries SHALL be invalid with cnt=0, and stall_cnt SHALL be 0.
REQ-031 While rst_n=0, outputs SHALL be forced to stall=0, iss_rdy=0, and fwd_sel=0.
REQ-032 Reset asserted mid-operation SHALL discard all pending entries with no retirement side effects.

Structure
REQ-033 Package fwd_pkg SHALL hold SELW, the FWD_RF=0 select constant, and the entry struct/typedef.
REQ-034 Sub-module fwd_sb_entry SHALL implement one scoreboard entry (load, count, retire, match); it is instantiated NPEND times.

Verification
REQ-035 Forwarding priority: fwd_wr_en=2'b11, fwd_rd={16,16}, ex_src[0]=16 -> fwd_sel[0]=1; set fwd_wr_en[0]=0 -> fwd_sel[0]=2.
REQ-036 Register zero: all stages write to rd=0, ex_src=0 -> fwd_sel=0 on all ports; same with ex_is_load and ex_rd=0 -> stall=0.
REQ-037 Load-use: ex_is_load=1, ex_rd=8, id_src[1]=8 with valid -> stall=1 and stall_cnt +1; id_src_vld[1]=0 -> stall=0.
REQ-038 Latency: issue rd=9 with lat=3, id_src[0]=9 -> stall=1 for exactly 3 cycles after issue edge, then 0; lat=0 -> 1 cycle.
REQ-039 Full table: 4 issues with lat=5 -> iss_rdy=0; fifth issue ignored; iss_rdy=1 the cycle after the first retirement.
REQ-040 Reset mid-op: 2 pending entries, rst_n=0 for 1 cycle -> iss_rdy=1 and stall=0 after release, and stall_cnt=0.
